// File: rtl/serdes_pkg.sv
// Shared state types for the serial/parallel converters.
package serdes_pkg;

    typedef enum logic {
        ST_DATA,
        ST_PARITY
    } state_t;

    typedef enum logic [1:0] {
        P2S_IDLE,
        P2S_DATA,
        P2S_PARITY
    } p2s_state_t;

endpackage

// File: rtl/s2p_out_buf.sv
// One-entry valid/ready holding register; a load overrides a same-cycle delivery.
module s2p_out_buf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_err,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            err   <= load_err;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-parallel converter with a 1-entry output register.
// Define S2P_PARITY_EN to append an even-parity bit to every word.
module serial_to_parallel
    import serdes_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    input  logic              s_data_i,
    output logic              s_ready_o,
    output logic              p_valid_o,
    output logic [DATA_W-1:0] p_data_o,
    input  logic              p_ready_i,
    output logic              p_err_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_bit;
    logic [DATA_W-1:0] word;
    logic              word_err;

`ifdef S2P_PARITY_EN
    state_t            state;
    logic [DATA_W-1:0] shreg;

    assign last_bit = (state == ST_PARITY);
    assign word     = shreg;
    assign word_err = ^{shreg, s_data_i};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_DATA;
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            if (state == ST_DATA) begin
                shreg <= {s_data_i, shreg[DATA_W-1:1]};
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    cnt   <= '0;
                    state <= ST_PARITY;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                state <= ST_DATA;
            end
        end
    end
`else
    // The final data bit goes straight to the output register, so only
    // DATA_W-1 bits need to be held here.
    localparam int SH_W = DATA_W - 1;

    logic [SH_W-1:0] shreg;
    logic [SH_W:0]   sh_next;

    assign sh_next  = {s_data_i, shreg};
    assign last_bit = (cnt == CNT_W'(DATA_W - 1));
    assign word     = sh_next;
    assign word_err = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            shreg <= sh_next[SH_W:1];
            cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end
`endif

    // Registers only: stall just the word-completing bit while the buffer is full.
    assign s_ready_o = !(last_bit && p_valid_o);
    assign accept    = s_valid_i && s_ready_o;

    s2p_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && last_bit),
        .load_data (word),
        .load_err  (word_err),
        .ready     (p_ready_i),
        .valid     (p_valid_o),
        .data      (p_data_o),
        .err       (p_err_o)
    );

endmodule

// File: tb/tb_serial_to_parallel.sv
// Randomized + directed bench for serial_to_parallel against a word-level model.
module tb_serial_to_parallel;

    localparam int DATA_W = 16;
`ifdef S2P_PARITY_EN
    localparam int WB  = DATA_W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int WB  = DATA_W;
    localparam bit PAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid_i, s_data_i, s_ready_o;
    logic              p_valid_o, p_ready_i, p_err_o;
    logic [DATA_W-1:0] p_data_o;

    serial_to_parallel #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .p_valid_o (p_valid_o),
        .p_data_o  (p_data_o),
        .p_ready_i (p_ready_i),
        .p_err_o   (p_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: counts accepted bits, holds one finished word.
    bit                mvalid;
    bit                merr;
    int                nbits;
    logic [DATA_W-1:0] mdata, partial;
    logic [DATA_W-1:0] mdeliv[$];

    always @(posedge clk or posedge reset) begin
        bit ready, acc, deliver, done;
        if (reset) begin
            mvalid = 0; merr = 0; nbits = 0; mdata = '0; partial = '0;
        end else begin
            ready   = !(mvalid && nbits == WB - 1);
            acc     = s_valid_i && ready;
            deliver = mvalid && p_ready_i;
            done    = 0;
            if (deliver) mdeliv.push_back(mdata);
            if (acc) begin
                if (nbits < DATA_W) partial[nbits] = s_data_i;
                nbits++;
                if (nbits == WB) begin
                    done  = 1;
                    nbits = 0;
                    mdata = partial;
                    merr  = PAR ? ((^partial) ^ s_data_i) : 1'b0;
                end
            end
            if (done) mvalid = 1;
            else if (deliver) mvalid = 0;
        end
    end

    // Per-cycle compare plus pulse bookkeeping.
    int cyc = 0;
    int vtimes[$];
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("s_ready", s_ready_o, !(mvalid && nbits == WB - 1));
            chk("p_valid", p_valid_o, mvalid);
            if (mvalid) begin
                chk("p_data", p_data_o, mdata);
                chk("p_err", p_err_o, merr);
            end
            if (p_valid_o) vtimes.push_back(cyc);
        end
    end

    bit rnd_pr = 0;
    int stalls = 0;

    task automatic send_bit(input logic b, input bit bubbles);
        bit hs = 0;
        int n  = 0;
        while (!hs && n < 300) begin
            @(negedge clk); #1;
            s_valid_i = bubbles ? 1'($urandom % 2) : 1'b1;
            s_data_i  = b;
            if (rnd_pr) p_ready_i = 1'($urandom % 2);
            hs = s_valid_i && s_ready_o;
            if (s_valid_i && !s_ready_o) stalls++;
            @(posedge clk);
            n++;
        end
        if (!hs) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=no_handshake required=handshake t=%0t", $time);
        end
    endtask

    task automatic send_bits(input logic [DATA_W-1:0] w, input int nb, input bit bubbles);
        for (int i = 0; i < nb; i++) send_bit(w[i], bubbles);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit bubbles, input logic pbit);
        send_bits(w, DATA_W, bubbles);
        if (PAR) send_bit(pbit, bubbles);
    endtask

    task automatic expect_word(input string name, input logic [DATA_W-1:0] w);
        @(negedge clk);
        chk({name, "_valid"}, p_valid_o, 1'b1);
        chk({name, "_data"}, p_data_o, w);
        #1 s_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1 s_valid_i = 1'b0;
        end
    endtask

    logic [DATA_W-1:0] sentq[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] w;
        reset = 1'b1; s_valid_i = 0; s_data_i = 0; p_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready_o, 1'b1);
        chk("rst_p_valid", p_valid_o, 1'b0);
        chk("rst_p_data", p_data_o, '0);
        chk("rst_p_err", p_err_o, 1'b0);
        #1 reset = 1'b0;

        // Single word, no gaps, one-cycle valid pulse.
        send_word(16'hA5C3, 0, ^16'hA5C3);
        expect_word("a5c3", 16'hA5C3);
        @(negedge clk);
        chk("a5c3_pulse_end", p_valid_o, 1'b0);

        // Backpressure: completing bit stalls until the held word is taken.
        mdeliv.delete();
        p_ready_i = 1'b0;
        send_word(16'h1234, 0, ^16'h1234);
        expect_word("w1234", 16'h1234);
        send_bits(16'hBEEF, PAR ? DATA_W : DATA_W - 1, 0);
        @(negedge clk);
        chk("bp_s_ready_low", s_ready_o, 1'b0);
        chk("bp_hold_data", p_data_o, 16'h1234);
        #1 s_valid_i = 1'b0; p_ready_i = 1'b1;
        w = 16'hBEEF;
        send_bit(PAR ? ^w : w[DATA_W-1], 0);
        expect_word("beef", 16'hBEEF);
        chk("bp_deliv_cnt", mdeliv.size(), 1);
        if (mdeliv.size() > 0) chk("bp_deliv_word", mdeliv[0], 16'h1234);

        // Random bubbles.
        idle(2);
        send_word(16'h0F0F, 1, ^16'h0F0F);
        expect_word("w0f0f", 16'h0F0F);

        // Reset mid-word discards partial bits.
        idle(2);
        send_bits(16'h7F7F, 7, 0);
        @(negedge clk); #1 s_valid_i = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("midrst_p_valid", p_valid_o, 1'b0);
        #1 reset = 1'b0;
        send_word(16'h8001, 0, ^16'h8001);
        expect_word("w8001", 16'h8001);

        // Four back-to-back words: pulse every WB cycles, no stalls.
        idle(3);
        stalls = 0;
        vtimes.delete();
        for (int k = 0; k < 4; k++) begin
            w = DATA_W'($urandom);
            send_word(w, 0, ^w);
        end
        expect_word("b2b_last", w);
        idle(3);
        chk("b2b_stalls", stalls, 0);
        chk("b2b_pulses", vtimes.size(), 4);
        for (int k = 1; k < vtimes.size(); k++)
            chk("b2b_spacing", vtimes[k] - vtimes[k-1], WB);

`ifdef S2P_PARITY_EN
        send_word(16'h0001, 0, 1'b1);
        @(negedge clk);
        chk("par_good_err", p_err_o, 1'b0);
        #1 s_valid_i = 1'b0;
        send_word(16'h0001, 0, 1'b0);
        @(negedge clk);
        chk("par_bad_err", p_err_o, 1'b1);
        #1 s_valid_i = 1'b0;
        idle(2);
`endif

        // Random traffic with random backpressure.
        mdeliv.delete();
        sentq.delete();
        rnd_pr = 1;
        for (int k = 0; k < 40; k++) begin
            w = DATA_W'($urandom);
            sentq.push_back(w);
            send_word(w, 1'($urandom % 2), 1'($urandom % 2));
        end
        rnd_pr = 0;
        @(negedge clk); #1 s_valid_i = 1'b0; p_ready_i = 1'b1;
        idle(5);
        chk("rnd_deliv_cnt", mdeliv.size(), sentq.size());
        for (int k = 0; k < sentq.size() && k < mdeliv.size(); k++)
            chk("rnd_deliv_word", mdeliv[k], sentq[k]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel.md
SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, setting the parallel word width in bits; legal range 2..64.
REQ-002 The block SHALL have input clk, 1 bit, the clock.
REQ-003 The block SHALL have input reset, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have input s_valid_i, 1 bit, meaning a serial bit is offered.
REQ-005 The block SHALL have input s_data_i, 1 bit, the serial data bit.
REQ-006 The block SHALL have output s_ready_o, 1 bit, meaning the block accepts the offered serial bit.
REQ-007 The block SHALL have output p_valid_o, 1 bit, meaning a parallel word is available.
REQ-008 The block SHALL have output p_data_o, DATA_W bits, the assembled parallel word.
REQ-009 The block SHALL have input p_ready_i, 1 bit, meaning downstream accepts the word.
REQ-010 The block SHALL have output p_err_o, 1 bit, the parity error flag, qualified by p_valid_o.

Function
REQ-011 A serial bit SHALL be accepted only in a cycle where s_valid_i and s_ready_o are both 1; a parallel word SHALL be delivered only in a cycle where p_valid_o and p_ready_i are both 1.
REQ-012 Serial bits SHALL be assembled LSB first: the first accepted bit of a word becomes p_data_o[0] and the DATA_W-th becomes p_data_o[DATA_W-1].
REQ-013 The block SHALL hold a shift register with a bit counter and a separate 1-entry output register (p_data_o, p_err_o, p_valid_o), so that collection of word N+1 overlaps holding of word N.
REQ-014 The FSM SHALL have two states: ST_DATA, which collects data bits with counter 0..DATA_W-1, and ST_PARITY, which is used only when S2P_PARITY_EN is defined.
REQ-015 When the final bit of a word is accepted, the word SHALL be written to the output register, and p_valid_o SHALL assert in the next cycle (latency 1 cycle from the final handshake).
REQ-016 s_ready_o SHALL be 0 only when the next accepted bit would complete a word and p_valid_o is 1; s_ready_o SHALL depend on registers only, with no combinational path from p_ready_i.
REQ-017 If a word is delivered and a new word completes in the same cycle, p_valid_o SHALL remain 1 and the output register SHALL update to the new word.
REQ-018 p_valid_o SHALL deassert the cycle after delivery unless REQ-017 applies; p_data_o and p_err_o SHALL stay stable while p_valid_o=1 and p_ready_i=0.
REQ-019 The counter SHALL wrap to 0 after the final bit of each word; cycles with s_valid_i=0 SHALL leave the counter and shift register unchanged.
REQ-020 With sustained s_valid_i=1 and p_ready_i=1, the block SHALL sustain one word per DATA_W cycles (DATA_W+1 with parity) and s_ready_o SHALL never drop.

Reset
REQ-021 Reset SHALL force the state to ST_DATA, the counter to 0, the shift register to 0, p_valid_o to 0, p_data_o to 0 and p_err_o to 0; s_ready_o SHALL therefore be 1 during and after reset.
REQ-022 Reset asserted mid-word SHALL discard all partial bits; the first bit accepted after reset SHALL be bit 0 of a new word.

Configuration
REQ-023 With S2P_PARITY_EN defined, each word SHALL be followed by one parity bit, accepted in ST_PARITY, and p_err_o SHALL be 1 when the XOR of the DATA_W data bits and the parity bit is 1 (even parity).
REQ-024 With S2P_PARITY_EN defined, the parity bit rather than the DATA_W-th data bit SHALL be the word-completing bit for REQ-015 and REQ-016.
REQ-025 Without S2P_PARITY_EN, ST_PARITY and its logic SHALL be absent and p_err_o SHALL be tied to 0.

Structure
REQ-026 State enum state_t (ST_DATA, ST_PARITY) SHALL reside in shared package serdes_pkg, alongside the parallel_to_serial state type.
REQ-027 Counter width SHALL be derived locally as $clog2(DATA_W+1).
REQ-028 The output holding register SHALL be one sub-module, s2p_out_buf: a 1-entry valid/ready register with a load port.

Verification
REQ-029 With DATA_W=16 and p_ready_i=1, sending 16'hA5C3 LSB first with no gaps SHALL assert p_valid_o for 1 cycle, one cycle after bit 15, with p_data_o=16'hA5C3.
REQ-030 With p_ready_i=0, sending 16'h1234 and then 15 bits of 16'hBEEF SHALL drive s_ready_o=0; raising p_ready_i SHALL deliver 16'h1234, then accept bit 15, then present 16'hBEEF.
REQ-031 Sending 16'h0F0F with random s_valid_i bubbles (about 50%) SHALL produce p_data_o=16'h0F0F.
REQ-032 Asserting reset after 7 bits, then sending 16'h8001, SHALL produce exactly 16'h8001 with no residue.
REQ-033 Sending four back-to-back words with s_valid_i=1 and p_ready_i=1 SHALL produce a p_valid_o pulse every 16 cycles, with s_ready_o constantly 1.
REQ-034 With S2P_PARITY_EN defined, 16'h0001 followed by parity bit 1 SHALL give p_err_o=0, and followed by parity bit 0 SHALL give p_err_o=1.
